// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter: two AXI4-Stream requesters share one master port.
// Whole packets are granted; the owner's beats pass through combinationally with zero latency.
//
//   state | meaning
//   IDLE  | no owner, nothing forwarded, both treadys low
//   PKT0  | requester 0 owns the master port until its tlast beat is accepted
//   PKT1  | requester 1 owns the master port until its tlast beat is accepted
module axis_rr_arbiter #(
  parameter int C_AXIS_DATA_WIDTH  = 512,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_CNT_WIDTH        = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s0_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s0_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s0_axis_tuser,
  input  logic                            s0_axis_tvalid,
  input  logic                            s0_axis_tlast,
  output logic                            s0_axis_tready,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s1_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s1_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s1_axis_tuser,
  input  logic                            s1_axis_tvalid,
  input  logic                            s1_axis_tlast,
  output logic                            s1_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic [1:0]                      grant,
  output logic [C_CNT_WIDTH-1:0]          pkt_cnt0,
  output logic [C_CNT_WIDTH-1:0]          pkt_cnt1
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PKT0 = 2'd1;
  localparam logic [1:0] ST_PKT1 = 2'd2;

  logic [1:0]             state_q, state_d;
  logic                   last_grant_q, last_grant_d;
  logic [C_CNT_WIDTH-1:0] pkt_cnt0_q, pkt_cnt0_d;
  logic [C_CNT_WIDTH-1:0] pkt_cnt1_q, pkt_cnt1_d;
  logic                   eop0, eop1;

  // m_axis_tready reaches the FSM only through these end-of-packet terms
  assign eop0 = (state_q == ST_PKT0) & s0_axis_tvalid & m_axis_tready & s0_axis_tlast;
  assign eop1 = (state_q == ST_PKT1) & s1_axis_tvalid & m_axis_tready & s1_axis_tlast;

  // Next-state: arbitrate in IDLE, release ownership and count on the accepted tlast beat
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    pkt_cnt0_d   = pkt_cnt0_q;
    pkt_cnt1_d   = pkt_cnt1_q;
    case (state_q)
      ST_IDLE: begin
        if (s0_axis_tvalid && s1_axis_tvalid) begin
          state_d = last_grant_q ? ST_PKT0 : ST_PKT1;
        end else if (s0_axis_tvalid) begin
          state_d = ST_PKT0;
        end else if (s1_axis_tvalid) begin
          state_d = ST_PKT1;
        end
      end
      ST_PKT0: begin
        if (eop0) begin
          state_d      = ST_IDLE;
          last_grant_d = 1'b0;
          pkt_cnt0_d   = pkt_cnt0_q + C_CNT_WIDTH'(1);
        end
      end
      ST_PKT1: begin
        if (eop1) begin
          state_d      = ST_IDLE;
          last_grant_d = 1'b1;
          pkt_cnt1_d   = pkt_cnt1_q + C_CNT_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers; last_grant resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      pkt_cnt0_q   <= '0;
      pkt_cnt1_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      pkt_cnt0_q   <= pkt_cnt0_d;
      pkt_cnt1_q   <= pkt_cnt1_d;
    end
  end

  // Datapath mux: owner passes straight through, everything else is held at zero
  always_comb begin
    m_axis_tdata   = '0;
    m_axis_tkeep   = '0;
    m_axis_tuser   = '0;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    case (state_q)
      ST_PKT0: begin
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tkeep   = s0_axis_tkeep;
        m_axis_tuser   = s0_axis_tuser;
        m_axis_tvalid  = s0_axis_tvalid;
        m_axis_tlast   = s0_axis_tlast;
        s0_axis_tready = m_axis_tready;
      end
      ST_PKT1: begin
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tkeep   = s1_axis_tkeep;
        m_axis_tuser   = s1_axis_tuser;
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tlast   = s1_axis_tlast;
        s1_axis_tready = m_axis_tready;
      end
      default: ;
    endcase
  end

  assign grant    = {state_q == ST_PKT1, state_q == ST_PKT0};
  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;

endmodule
